// File: rtl/qspi_pkg.sv
// Shared constants and state encoding for the QSPI quad-read master.
package qspi_pkg;
  localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;
  localparam logic [2:0] CMD_BITS_LAST  = 3'd7;
  localparam logic [2:0] ADDR_NIBS_LAST = 3'd5;
  localparam logic [2:0] MODE_NIBS_LAST = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA, ST_DESEL
  } qspi_rd_state_t;
endpackage

// File: rtl/qspi_sclk_gen.sv
// SPI-mode-0 serial clock generator: CLK_DIV clks per half-period, rise held off while stalled.
module qspi_sclk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic gate,
  input  logic stall,
  output logic sclk,
  output logic tick,
  output logic rise,
  output logic fall
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  // tick/rise/fall mark the clk edge on which sclk will toggle
  assign tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = tick && gate && !sclk && !stall;
  assign fall = tick && gate && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (!gate)     sclk <= 1'b0;
      else if (rise) sclk <= 1'b1;
      else if (fall) sclk <= 1'b0;
    end
  end
endmodule

// File: rtl/qspi_flash_reader.sv
// Quad I/O Fast Read (0xEB) master; first transaction sends the command, later ones use continuous-read mode.
module qspi_flash_reader
  import qspi_pkg::*;
#(
  parameter int         CLK_DIV       = 1,
  parameter int         LEN_W         = 16,
  parameter logic [7:0] MODE_BYTE     = 8'hA0,
  parameter int         DUMMY_NIBBLES = 4,
  parameter int         CS_IDLE       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             busy,
  output logic             flash_cs,
  output logic             flash_sclk,
  output logic [3:0]       flash_io_out,
  output logic [3:0]       flash_io_oe,
  input  logic [3:0]       flash_io_in
);
  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIBBLES - 1);
  localparam logic [2:0] DESEL_LAST = 3'(CS_IDLE - 1);

  qspi_rd_state_t   state;
  logic             cont_mode;
  logic [2:0]       cnt;
  logic [30:0]      sh;      // bits still to send after the one on the pins
  logic [3:0]       hi_nib;
  logic [LEN_W-1:0] rem;
  logic             en, gate, stall, tick, rise, fall;

  assign en        = (state != ST_IDLE);
  assign gate      = (state != ST_IDLE) && (state != ST_DESEL);
  // hold the clock low before the nibble that would overwrite an unaccepted byte
  assign stall     = (state == ST_DATA) && cnt[0] && out_valid && !out_ready;
  assign req_ready = (state == ST_IDLE) && !out_valid;
  assign busy      = (state != ST_IDLE);

  qspi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk(clk), .rst_n(rst_n), .en(en), .gate(gate), .stall(stall),
    .sclk(flash_sclk), .tick(tick), .rise(rise), .fall(fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cont_mode    <= 1'b0;
      cnt          <= '0;
      sh           <= '0;
      hi_nib       <= '0;
      rem          <= '0;
      out_valid    <= 1'b0;
      out_byte     <= '0;
      flash_cs     <= 1'b1;
      flash_io_out <= '0;
      flash_io_oe  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: if (req_valid && req_ready && (req_len != '0)) begin
          rem      <= req_len;
          cnt      <= '0;
          flash_cs <= 1'b0;
          if (cont_mode) begin
            state        <= ST_ADDR;
            flash_io_out <= req_addr[23:20];
            flash_io_oe  <= 4'hF;
            sh           <= {req_addr[19:0], 11'b0};
          end else begin
            state        <= ST_CMD;
            flash_io_out <= {3'b000, CMD_QUAD_READ[7]};
            flash_io_oe  <= 4'b0001;
            sh           <= {CMD_QUAD_READ[6:0], req_addr};
          end
        end
        ST_CMD: if (fall) begin
          if (cnt == CMD_BITS_LAST) begin
            state        <= ST_ADDR;
            cont_mode    <= 1'b1;
            cnt          <= '0;
            flash_io_out <= sh[30:27];
            flash_io_oe  <= 4'hF;
            sh           <= {sh[26:0], 4'b0};
          end else begin
            cnt          <= cnt + 3'd1;
            flash_io_out <= {3'b000, sh[30]};
            sh           <= {sh[29:0], 1'b0};
          end
        end
        ST_ADDR: if (fall) begin
          if (cnt == ADDR_NIBS_LAST) begin
            state        <= ST_MODE;
            cnt          <= '0;
            flash_io_out <= MODE_BYTE[7:4];
            sh           <= {MODE_BYTE[3:0], 27'b0};
          end else begin
            cnt          <= cnt + 3'd1;
            flash_io_out <= sh[30:27];
            sh           <= {sh[26:0], 4'b0};
          end
        end
        ST_MODE: if (fall) begin
          if (cnt == MODE_NIBS_LAST) begin
            state        <= ST_DUMMY;
            cnt          <= '0;
            flash_io_out <= '0;
            flash_io_oe  <= '0;
          end else begin
            cnt          <= cnt + 3'd1;
            flash_io_out <= sh[30:27];
          end
        end
        ST_DUMMY: if (fall) begin
          if (cnt == DUMMY_LAST) begin
            state <= ST_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_DATA: begin
          if (rise) begin
            if (!cnt[0]) begin
              hi_nib <= flash_io_in;
            end else begin
              out_byte  <= {hi_nib, flash_io_in};
              out_valid <= 1'b1;
              if (rem != '0) rem <= rem - LEN_W'(1);
            end
          end else if (fall) begin
            cnt <= {2'b00, ~cnt[0]};
            if (cnt[0] && (rem == '0)) begin
              state    <= ST_DESEL;
              cnt      <= '0;
              flash_cs <= 1'b1;
            end
          end
        end
        ST_DESEL: if (tick) begin
          if (cnt == DESEL_LAST) state <= ST_IDLE;
          else                   cnt   <= cnt + 3'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qspi_flash_reader.sv
// Bench for qspi_flash_reader against a behavioural quad-read flash (mem[i] = i ^ 8'h5A).
module tb_qspi_flash_reader;
  localparam int DIV = 3;
  localparam int CSI = 2;
  localparam int DUM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;
  logic        busy, flash_cs, flash_sclk;
  logic [3:0]  flash_io_out, flash_io_oe, flash_io_in;
  logic        model_rst = 1'b0;

  always #5 clk = ~clk;

  qspi_flash_reader #(.CLK_DIV(DIV), .LEN_W(16), .MODE_BYTE(8'hA0),
                      .DUMMY_NIBBLES(DUM), .CS_IDLE(CSI)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .busy(busy), .flash_cs(flash_cs), .flash_sclk(flash_sclk),
    .flash_io_out(flash_io_out), .flash_io_oe(flash_io_oe), .flash_io_in(flash_io_in)
  );

  // flash responder model
  int          m_rises = 0, m_base = 8, m_j = 0;
  bit          m_cont = 0, m_cont_start = 0, m_cmd_seen = 0, m_oe_ok = 1;
  logic [7:0]  m_cmd = '0, m_mode = '0, m_b = '0;
  logic [23:0] m_addr = '0;
  logic [3:0]  m_first = '0, io_drv = '0;

  always @(posedge flash_sclk or negedge flash_cs or posedge model_rst) begin
    if (model_rst) begin
      m_cont = 0;
    end else if (!flash_sclk) begin
      m_rises = 0; m_cont_start = m_cont; m_cmd_seen = 0; m_oe_ok = 1;
      m_addr = '0; m_cmd = '0;
    end else if (!flash_cs) begin
      m_base = m_cont_start ? 0 : 8;
      if (m_rises == 0) m_first = flash_io_out;
      if (m_rises < m_base) begin
        m_cmd = {m_cmd[6:0], flash_io_out[0]};
        if (flash_io_oe !== 4'b0001) m_oe_ok = 0;
        if (m_rises == 7) m_cmd_seen = (m_cmd == 8'hEB);
      end else if (m_rises < m_base + 6) begin
        m_addr = {m_addr[19:0], flash_io_out};
        if (flash_io_oe !== 4'hF) m_oe_ok = 0;
      end else if (m_rises < m_base + 8) begin
        m_mode = {m_mode[3:0], flash_io_out};
        if (m_rises == m_base + 7) m_cont = (m_mode[7:4] == 4'hA);
      end
      m_rises++;
    end
  end

  always @(negedge flash_sclk) begin
    if (!flash_cs) begin
      m_j = m_rises - ((m_cont_start ? 0 : 8) + 8 + DUM);
      if (m_j >= 0) begin
        m_b = 8'(m_addr + 24'(m_j / 2)) ^ 8'h5A;
        io_drv = m_j[0] ? m_b[3:0] : m_b[7:4];
      end
    end
  end
  assign flash_io_in = io_drv;

  // bus monitor: sclk period and chip-select idle time
  int   cyc = 0, last_rise = -1, min_per = 1000, max_per = 0, per = 0;
  int   cs_hi = 0, cs_hi_last = 0, cs_falls = 0, rises_mon = 0;
  logic sclk_q = 1'b0, cs_q = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (flash_sclk && !sclk_q) begin
      if (last_rise >= 0) begin
        per = cyc - last_rise;
        if (per < min_per) min_per = per;
        if (per > max_per) max_per = per;
      end
      last_rise = cyc;
      rises_mon++;
    end
    if (!flash_cs && cs_q) begin
      cs_hi_last = cs_hi; cs_falls++; last_rise = -1; min_per = 1000; max_per = 0;
    end
    cs_hi  = flash_cs ? cs_hi + 1 : 0;
    sclk_q = flash_sclk;
    cs_q   = flash_cs;
  end

  int         checks = 0, errors = 0, popped = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // advance one clock; score any byte handed over at that edge
  task automatic step();
    logic       hs;
    logic [7:0] b;
    hs = out_valid && out_ready && rst_n;
    b  = out_byte;
    @(posedge clk); #1;
    if (hs) begin
      popped++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_byte actual=%0h required=none", b);
      end else begin
        chk("out_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic do_req(input logic [23:0] a, input logic [15:0] l);
    int n = 0;
    while (!req_ready && n < 2000) begin step(); n++; end
    chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = a; req_len = l;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(8'(a + 24'(i)) ^ 8'h5A);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int n = 0; n < 5000; n++) begin
      if (!busy && !out_valid && exp_q.size() == 0) begin ok = 1; break; end
      step();
    end
    chk(name, {31'b0, ok}, 32'd1);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [15:0] len;
    bit          cmd;
    int          stall_after;
  } vec_t;
  vec_t vt[4];

  initial begin
    int p0, r0, f0, nov, nrdy;
    bit ok;
    vt[0] = '{24'h000000, 16'd4, 1'b1, -1};
    vt[1] = '{24'h000010, 16'd2, 1'b0, -1};
    vt[2] = '{24'h000040, 16'd8, 1'b0, 2};
    vt[3] = '{24'hFFFFFE, 16'd3, 1'b0, -1};

    repeat (3) step();
    chk("rst_cs",        {31'b0, flash_cs},    32'd1);
    chk("rst_sclk",      {31'b0, flash_sclk},  32'd0);
    chk("rst_oe",        {28'b0, flash_io_oe}, 32'd0);
    chk("rst_io_out",    {28'b0, flash_io_out},32'd0);
    chk("rst_out_valid", {31'b0, out_valid},   32'd0);
    chk("rst_out_byte",  {24'b0, out_byte},    32'd0);
    chk("rst_req_ready", {31'b0, req_ready},   32'd1);
    chk("rst_busy",      {31'b0, busy},        32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      p0 = popped;
      do_req(vt[i].addr, vt[i].len);
      if (vt[i].stall_after >= 0) begin
        ok = 0;
        for (int n = 0; n < 2000; n++) begin
          if (popped >= p0 + vt[i].stall_after) begin ok = 1; break; end
          step();
        end
        chk("stall_start_timeout", {31'b0, ok}, 32'd1);
        out_ready = 1'b0;
        repeat (30) step();
        r0 = rises_mon;
        repeat (10) step();
        chk("stall_sclk_frozen", rises_mon, r0);
        chk("stall_sclk_low", {31'b0, flash_sclk}, 32'd0);
        chk("stall_valid_held", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
      end
      wait_done("txn_done");
      chk("cmd_phase",    {31'b0, m_cmd_seen}, {31'b0, vt[i].cmd});
      chk("first_nibble", {28'b0, m_first}, vt[i].cmd ? 32'd1 : {28'b0, vt[i].addr[23:20]});
      chk("addr_rx",      {8'b0, m_addr}, {8'b0, vt[i].addr});
      chk("oe_pattern",   {31'b0, m_oe_ok}, 32'd1);
      chk("cs_high_after",{31'b0, flash_cs}, 32'd1);
      if (i > 0) chk("cs_idle_time", {31'b0, cs_hi_last >= CSI * DIV}, 32'd1);
      if (i == 0) begin
        chk("sclk_min_period", min_per, 2 * DIV);
        chk("sclk_max_period", max_per, 2 * DIV);
      end
    end

    f0 = cs_falls; nov = 0; nrdy = 0;
    do_req(24'h000100, 16'd0);
    repeat (20) begin
      step();
      if (out_valid) nov++;
      if (!req_ready) nrdy++;
    end
    chk("len0_no_cs",    cs_falls - f0, 0);
    chk("len0_ready",    nrdy, 0);
    chk("len0_no_valid", nov, 0);

    f0 = cs_falls;
    do_req(24'h000080, 16'd16);
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      if (cs_falls > f0 && m_rises >= 8 + DUM + 6) begin ok = 1; break; end
      step();
    end
    chk("data_phase_timeout", {31'b0, ok}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs",    {31'b0, flash_cs},    32'd1);
    chk("midrst_oe",    {28'b0, flash_io_oe}, 32'd0);
    chk("midrst_sclk",  {31'b0, flash_sclk},  32'd0);
    chk("midrst_valid", {31'b0, out_valid},   32'd0);
    chk("midrst_busy",  {31'b0, busy},        32'd0);
    exp_q.delete();
    model_rst = 1'b1; #1; model_rst = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    do_req(24'h000020, 16'd2);
    wait_done("rerst_done");
    chk("rerst_cmd",  {31'b0, m_cmd_seen}, 32'd1);
    chk("rerst_addr", {8'b0, m_addr}, 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
